// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - text-mode geometry constants and writer state type
package vga_text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELL_W = 8;
    localparam int CELL_H = 16;
    localparam int DEPTH  = COLS * ROWS;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/text_addr_gen.sv
// rtl/text_addr_gen.sv - pixel coordinate to character cell address, shift-add only
module text_addr_gen
    import vga_text_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic [AW-1:0] addr
);

    localparam int XS = $clog2(CELL_W);
    localparam int YS = $clog2(CELL_H);

    logic [AW-1:0] row;
    logic [AW-1:0] col;

    assign row  = AW'(y >> YS);
    assign col  = AW'(x >> XS);
    // row*80 as row*64 + row*16
    assign addr = (row << 6) + (row << 4) + col;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - character RAM port shared by display fetch (priority) and a writer
module vram_arbiter #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int AW         = 12,
    parameter int DW         = 8,
    parameter bit BLANK_ONLY = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_drop,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] disp_char,
    output logic          disp_valid,
    output logic          frame_tick,
    output logic [7:0]    frame_cnt
);
    import vga_text_pkg::*;

    localparam logic [AW:0] CELLS = (AW+1)'(COLS * ROWS);

    wr_state_t     wstate;
    logic          ptick_d;
    logic          rise;
    logic          fetch_due;
    logic          rd_p1;
    logic          vblank_s;
    logic          grant;
    logic          in_range;
    logic          wr_do;
    logic [AW-1:0] cell_addr;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;

    text_addr_gen #(.AW(AW)) u_addr_gen (
        .x    (pixel_x),
        .y    (pixel_y),
        .addr (cell_addr)
    );

    assign rise     = p_tick & ~ptick_d;
    assign in_range = ({1'b0, wr_addr} < CELLS);
    // rst_n term keeps the RAM port quiet while reset is held with wr_req high
    assign grant    = rst_n & ~fetch_due & (wstate == W_IDLE) & wr_req & (~BLANK_ONLY | ~video_on);
    assign wr_do    = grant & in_range;

    assign ram_en    = fetch_due | wr_do;
    assign ram_we    = wr_do;
    assign ram_addr  = fetch_due ? fetch_addr : (wr_do ? wr_addr : addr_hold);
    assign ram_wdata = wr_do ? wr_data : wdata_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptick_d    <= 1'b0;
            fetch_due  <= 1'b0;
            fetch_addr <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            rd_p1      <= 1'b0;
            disp_valid <= 1'b0;
            disp_char  <= '0;
            vblank_s   <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            ptick_d    <= p_tick;
            fetch_due  <= rise & video_on & (pixel_x[2:0] == 3'd0);
            if (rise)
                fetch_addr <= cell_addr;
            if (ram_en)
                addr_hold <= ram_addr;
            if (wr_do)
                wdata_hold <= wr_data;
            rd_p1      <= fetch_due;
            disp_valid <= rd_p1;
            if (rd_p1)
                disp_char <= ram_rdata;
            frame_tick <= 1'b0;
            if (rise) begin
                vblank_s <= (pixel_y == 10'h3FF);
                if ((pixel_y == 10'h3FF) && !vblank_s) begin
                    frame_tick <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            wr_ack  <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_ack  <= 1'b0;
            wr_drop <= 1'b0;
            case (wstate)
                W_IDLE: if (grant) begin
                    wstate  <= W_ACK;
                    wr_ack  <= 1'b1;
                    wr_drop <= ~in_range;
                end
                W_ACK:  wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule
